// File: rtl/dsp_wresp_ooo_channel.sv
// Write-response dispatcher: per-slave B FIFOs, compacting AW tracker, registered master B.
// Define DSP_WRESP_DECERR_EN to answer undecoded AWs locally with DECERR.
module dsp_wresp_ooo_channel #(
  parameter int SLV_AMT         = 2,
  parameter int OUTSTANDING_AMT = 8,
  parameter int OUTST_CTN_W     = $clog2(OUTSTANDING_AMT) + 1,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int ORDER_MODE      = 1
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [SLV_ID_W-1:0]                 dsp_AW_slv_id_i,
  input  logic [TRANS_MST_ID_W-1:0]           dsp_AW_id_i,
  input  logic                                dsp_AW_decerr_i,
  input  logic                                dsp_AW_shift_en_i,
  output logic                                dsp_AW_full_o,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]   sa_BID_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]  sa_BRESP_i,
  input  logic [SLV_AMT-1:0]                  sa_BVALID_i,
  output logic [SLV_AMT-1:0]                  sa_BREADY_o,
  output logic [OUTST_CTN_W-1:0]              sa_B_outst_ctn_o,
  output logic [TRANS_MST_ID_W-1:0]           m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]          m_BRESP_o,
  output logic                                m_BVALID_o,
  input  logic                                m_BREADY_i
);
  localparam int OA = OUTSTANDING_AMT;
  localparam int PW = (OA > 1) ? $clog2(OA) : 1;
  localparam int IW = TRANS_MST_ID_W;
  localparam int RW = TRANS_WR_RESP_W;
  localparam int CW = OUTST_CTN_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(OA);

  logic [SLV_ID_W-1:0] trk_slv_q [OA];
  logic [SLV_ID_W-1:0] trk_slv_d [OA];
  logic [IW-1:0]       trk_id_q  [OA];
  logic [IW-1:0]       trk_id_d  [OA];
  logic [OA-1:0]       trk_vld_q, trk_vld_d;
  logic [OA-1:0]       trk_dec_q;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_rm;
  logic                push;

`ifdef DSP_WRESP_DECERR_EN
  logic [OA-1:0]       trk_dec_d;
`else
  logic                unused_decerr;
  assign trk_dec_q     = '0;
  assign unused_decerr = dsp_AW_decerr_i;
`endif

  logic [IW-1:0]      fbid_q [SLV_AMT][OA];
  logic [RW-1:0]      frsp_q [SLV_AMT][OA];
  logic [PW-1:0]      rptr_q [SLV_AMT];
  logic [PW-1:0]      rptr_d [SLV_AMT];
  logic [PW-1:0]      wptr_q [SLV_AMT];
  logic [PW-1:0]      wptr_d [SLV_AMT];
  logic [CW-1:0]      fcnt_q [SLV_AMT];
  logic [CW-1:0]      fcnt_d [SLV_AMT];
  logic [SLV_AMT-1:0] brdy_q, brdy_d;
  logic [SLV_AMT-1:0] f_push, f_pop, f_nemp;
  logic [IW-1:0]      head_id  [SLV_AMT];
  logic [RW-1:0]      head_rsp [SLV_AMT];

  logic [OA-1:0]       elig;
  logic                can_load, sel_found, win, sel_dec;
  logic [PW-1:0]       sel_k;
  logic [SLV_ID_W-1:0] sel_slv;
  logic [IW-1:0]       sel_id;

  logic          mv_q, mv_d;
  logic [IW-1:0] mbid_q, mbid_d;
  logic [RW-1:0] mrsp_q, mrsp_d;

  always_comb begin
    for (int s = 0; s < SLV_AMT; s++) begin
      head_id[s]  = fbid_q[s][rptr_q[s]];
      head_rsp[s] = frsp_q[s][rptr_q[s]];
      f_nemp[s]   = (fcnt_q[s] != '0);
      f_push[s]   = sa_BVALID_i[s] & brdy_q[s];
    end
  end

  // Age/ID eligibility; the lowest eligible index wins.
  always_comb begin
    can_load  = ~mv_q | m_BREADY_i;
    elig      = '0;
    sel_found = 1'b0;
    sel_k     = '0;
    for (int k = 0; k < OA; k++) begin
      elig[k] = trk_vld_q[k] & (f_nemp[trk_slv_q[k]] | trk_dec_q[k]);
      if (ORDER_MODE != 0) begin
        if (!trk_dec_q[k] && head_id[trk_slv_q[k]] != trk_id_q[k])
          elig[k] = 1'b0;
        for (int j = 0; j < k; j++)
          if (trk_vld_q[j] && trk_id_q[j] == trk_id_q[k])
            elig[k] = 1'b0;
      end else if (k != 0) begin
        elig[k] = 1'b0;
      end
    end
    for (int k = OA - 1; k >= 0; k--) begin
      if (elig[k]) begin
        sel_found = 1'b1;
        sel_k     = PW'(k);
      end
    end
    win     = can_load & sel_found;
    sel_slv = trk_slv_q[sel_k];
    sel_id  = trk_id_q[sel_k];
    sel_dec = trk_dec_q[sel_k];
  end

  always_comb begin
    for (int s = 0; s < SLV_AMT; s++) begin
      f_pop[s]  = win & ~sel_dec & (int'(sel_slv) == s);
      rptr_d[s] = rptr_q[s];
      wptr_d[s] = wptr_q[s];
      if (f_pop[s])
        rptr_d[s] = (rptr_q[s] == PW'(OA - 1)) ? '0 : rptr_q[s] + 1'b1;
      if (f_push[s])
        wptr_d[s] = (wptr_q[s] == PW'(OA - 1)) ? '0 : wptr_q[s] + 1'b1;
      fcnt_d[s] = fcnt_q[s] + CW'(f_push[s]) - CW'(f_pop[s]);
      brdy_d[s] = (fcnt_d[s] != FULL_CNT);
    end
  end

  // Removal compacts first; a push then lands at the new tail.
  always_comb begin
    trk_vld_d = trk_vld_q;
    trk_slv_d = trk_slv_q;
    trk_id_d  = trk_id_q;
`ifdef DSP_WRESP_DECERR_EN
    trk_dec_d = trk_dec_q;
`endif
    push   = dsp_AW_shift_en_i & (cnt_q != FULL_CNT);
    cnt_rm = cnt_q - CW'(win);
    if (win) begin
      for (int k = 0; k < OA - 1; k++) begin
        if (k >= int'(sel_k)) begin
          trk_vld_d[k] = trk_vld_q[k+1];
          trk_slv_d[k] = trk_slv_q[k+1];
          trk_id_d[k]  = trk_id_q[k+1];
`ifdef DSP_WRESP_DECERR_EN
          trk_dec_d[k] = trk_dec_q[k+1];
`endif
        end
      end
      trk_vld_d[OA-1] = 1'b0;
    end
    for (int k = 0; k < OA; k++) begin
      if (push && k == int'(cnt_rm)) begin
        trk_vld_d[k] = 1'b1;
        trk_slv_d[k] = dsp_AW_slv_id_i;
        trk_id_d[k]  = dsp_AW_id_i;
`ifdef DSP_WRESP_DECERR_EN
        trk_dec_d[k] = dsp_AW_decerr_i;
`endif
      end
    end
    cnt_d = cnt_rm + CW'(push);
  end

  always_comb begin
    mv_d   = mv_q;
    mbid_d = mbid_q;
    mrsp_d = mrsp_q;
    if (win) begin
      mv_d   = 1'b1;
      mbid_d = sel_dec ? sel_id : head_id[sel_slv];
      mrsp_d = sel_dec ? {RW{1'b1}} : head_rsp[sel_slv];
    end else if (can_load) begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      cnt_q     <= '0;
      trk_vld_q <= '0;
      for (int k = 0; k < OA; k++) begin
        trk_slv_q[k] <= '0;
        trk_id_q[k]  <= '0;
      end
`ifdef DSP_WRESP_DECERR_EN
      trk_dec_q <= '0;
`endif
      brdy_q <= '1;
      for (int s = 0; s < SLV_AMT; s++) begin
        rptr_q[s] <= '0;
        wptr_q[s] <= '0;
        fcnt_q[s] <= '0;
        for (int e = 0; e < OA; e++) begin
          fbid_q[s][e] <= '0;
          frsp_q[s][e] <= '0;
        end
      end
      mv_q   <= 1'b0;
      mbid_q <= '0;
      mrsp_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      trk_vld_q <= trk_vld_d;
      trk_slv_q <= trk_slv_d;
      trk_id_q  <= trk_id_d;
`ifdef DSP_WRESP_DECERR_EN
      trk_dec_q <= trk_dec_d;
`endif
      brdy_q <= brdy_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      fcnt_q <= fcnt_d;
      for (int s = 0; s < SLV_AMT; s++) begin
        if (f_push[s]) begin
          fbid_q[s][wptr_q[s]] <= sa_BID_i[s*IW +: IW];
          frsp_q[s][wptr_q[s]] <= sa_BRESP_i[s*RW +: RW];
        end
      end
      mv_q   <= mv_d;
      mbid_q <= mbid_d;
      mrsp_q <= mrsp_d;
    end
  end

  assign dsp_AW_full_o    = (cnt_q == FULL_CNT);
  assign sa_BREADY_o      = brdy_q;
  assign sa_B_outst_ctn_o = cnt_q;
  assign m_BVALID_o       = mv_q;
  assign m_BID_o          = mbid_q;
  assign m_BRESP_o        = mrsp_q;

endmodule
